// File: rtl/case_code_encoder_if.sv
// Stream interface for case_code_encoder.
//   in_valid / in_ready / in_t        : upstream 3-bit value handshake
//   out_valid / out_ready / out_cond  : downstream 4-bit condition code handshake
// slave  : encoder side (accepts in_t, produces out_cond)
// master : environment side (produces in_t, consumes out_cond)
interface case_code_encoder_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_t;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_cond;

   modport slave (
      input  in_valid, in_t, out_ready,
      output in_ready, out_valid, out_cond
   );

   modport master (
      output in_valid, in_t, out_ready,
      input  in_ready, out_valid, out_cond
   );
endinterface

// File: rtl/case_code_encoder.sv
// case_code_encoder: encodes a 3-bit value t into a 4-bit condition code
// {~t, 1'b0} through a 2-entry FIFO, and can run a self-check sweep that
// pushes all 8 codes and compares the value returned by the downstream
// decoder (chk_t) CHECK_LAT cycles after each output handshake.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   bus          : stream interface (slave modport), in_t in / out_cond out
//   sweep_start  : request a sweep (accepted only in IDLE with FIFO empty)
//   sweep_busy   : sweep in progress (SEND or DRAIN)
//   sweep_done   : one-cycle pulse when the sweep completes
//   chk_t        : decoder return value, only looked at during a sweep
//   err_count    : saturating sweep mismatch count
//
// state | meaning
// IDLE  | normal streaming, in_ready may be high
// SEND  | sweep: push t = 7 - i while FIFO has room
// DRAIN | sweep: all 8 pushed, waiting for the remaining checks
// DONE  | sweep finished, sweep_done pulses for one cycle
module case_code_encoder #(
   parameter int CHECK_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   case_code_encoder_if.slave   bus,
   input  logic                 sweep_start,
   output logic                 sweep_busy,
   output logic                 sweep_done,
   input  logic [2:0]           chk_t,
   output logic [3:0]           err_count
);

   localparam int LAST = CHECK_LAT - 1;

   typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

   state_t     state, state_nxt;

   logic [2:0] mem [2];
   logic       wr_ptr, rd_ptr;
   logic [1:0] count;
   logic       full, empty;
   logic       ready_en;
   logic       push, pop, ext_push;
   logic [2:0] push_t;
   logic [2:0] head_t;

   logic [2:0] idx;
   logic       sweep_push;
   logic       sweep_accept;

   logic       chk_v  [CHECK_LAT];
   logic [2:0] chk_tq [CHECK_LAT];
   logic       chk_fire;
   logic [3:0] chk_left;
   logic       track;

   assign full   = (count == 2'd2);
   assign empty  = (count == 2'd0);
   assign head_t = mem[rd_ptr];

   // A sweep_start that will be accepted this cycle blocks the external push,
   // so the FIFO only ever holds sweep entries while a sweep runs.
   assign bus.in_ready  = ready_en && (state == IDLE) && !full && !(sweep_start && empty);
   assign bus.out_valid = !empty;
   assign bus.out_cond  = empty ? 4'h0 : {~head_t, 1'b0};

   assign ext_push = bus.in_valid && bus.in_ready;
   assign push     = ext_push || sweep_push;
   assign push_t   = sweep_push ? ~idx : bus.in_t;
   assign pop      = bus.out_valid && bus.out_ready;

   assign track    = pop && sweep_busy;
   assign chk_fire = chk_v[LAST] && sweep_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      sweep_push   = 1'b0;
      sweep_accept = 1'b0;
      sweep_busy   = 1'b0;
      sweep_done   = 1'b0;
      case (state)
         IDLE: begin
            if (sweep_start && empty) begin
               sweep_accept = 1'b1;
               state_nxt    = SEND;
            end
         end
         SEND: begin
            sweep_busy = 1'b1;
            if (!full) begin
               sweep_push = 1'b1;
               if (idx == 3'd7) begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            sweep_busy = 1'b1;
            if (chk_fire && (chk_left == 4'd1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            sweep_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ready_en keeps in_ready low during reset and for no longer than the
   // first cycle after it.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_en <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
      end else begin
         ready_en <= 1'b1;
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_t;
      end
   end

   // Sweep index and remaining-checks down-counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx      <= 3'd0;
         chk_left <= 4'd0;
      end else begin
         if (sweep_accept) begin
            idx <= 3'd0;
         end else if (sweep_push) begin
            idx <= idx + 3'd1;
         end
         if (sweep_accept) begin
            chk_left <= 4'd8;
         end else if (chk_fire) begin
            chk_left <= chk_left - 4'd1;
         end
      end
   end

   // Check pipeline: stage 0 captures the popped t; the last stage lines up
   // with the cycle in which the decoder result is due on chk_t.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < CHECK_LAT; k++) begin
            chk_v[k]  <= 1'b0;
            chk_tq[k] <= 3'd0;
         end
      end else begin
         chk_v[0]  <= track;
         chk_tq[0] <= head_t;
         for (int k = 1; k < CHECK_LAT; k++) begin
            chk_v[k]  <= chk_v[k-1];
            chk_tq[k] <= chk_tq[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_count <= 4'd0;
      end else if (sweep_accept) begin
         err_count <= 4'd0;
      end else if (chk_fire && (chk_t != chk_tq[LAST]) && (err_count != 4'd15)) begin
         err_count <= err_count + 4'd1;
      end
   end

endmodule

// File: tb/tb_case_code_encoder.sv
module tb_case_code_encoder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   case_code_encoder_if bus_a ();
   case_code_encoder_if bus_b ();

   logic       start_a, busy_a, done_a;
   logic [2:0] chk_a;
   logic [3:0] err_a;
   logic       start_b, busy_b, done_b;
   logic [2:0] chk_b;
   logic [3:0] err_b;

   logic       loop_a;
   logic [2:0] dec_a;

   int checks = 0;
   int failures = 0;
   int done_a_cnt = 0;

   case_code_encoder #(.CHECK_LAT(1)) dut_a (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_a),
      .sweep_start (start_a),
      .sweep_busy  (busy_a),
      .sweep_done  (done_a),
      .chk_t       (chk_a),
      .err_count   (err_a)
   );

   case_code_encoder #(.CHECK_LAT(4)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_b),
      .sweep_start (start_b),
      .sweep_busy  (busy_b),
      .sweep_done  (done_b),
      .chk_t       (chk_b),
      .err_count   (err_b)
   );

   // Ideal decoder for dut_a: returns t one cycle after each handshake.
   always @(posedge clk) begin
      if (bus_a.out_valid && bus_a.out_ready) begin
         dec_a <= ~bus_a.out_cond[3:1];
      end
   end
   assign chk_a = loop_a ? dec_a : 3'b000;
   assign chk_b = 3'b000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (done_a) done_a_cnt++;
   endtask

   task automatic run_sweep_a(input int exp_err);
      int seen;
      bit got;
      seen = 0;
      got  = 1'b0;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      check("sweep_a_busy", busy_a, 1);
      check("sweep_a_err_clr", err_a, 0);
      for (int c = 0; c < 60 && !got; c++) begin
         if (bus_a.out_valid && bus_a.out_ready) begin
            check("sweep_a_code", bus_a.out_cond, seen * 2);
            seen++;
         end
         step();
         if (done_a) got = 1'b1;
      end
      check("sweep_a_done", got, 1);
      check("sweep_a_ncodes", seen, 8);
      check("sweep_a_err", err_a, exp_err);
      check("sweep_a_busy_done", busy_a, 0);
      step();
      check("sweep_a_done_pulse", done_a, 0);
      check("sweep_a_err_hold", err_a, exp_err);
   endtask

   initial begin
      logic [3:0] exp_seq [8];
      int seen;
      int base;
      bit got;
      exp_seq = '{4'hE, 4'hC, 4'hA, 4'h8, 4'h6, 4'h4, 4'h2, 4'h0};

      bus_a.in_valid = 1'b0; bus_a.in_t = 3'd0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_t = 3'd0; bus_b.out_ready = 1'b0;
      start_a = 1'b0; start_b = 1'b0; loop_a = 1'b1;

      // Reset state
      reset = 1'b1;
      step();
      step();
      check("rst_out_valid", bus_a.out_valid, 0);
      check("rst_in_ready", bus_a.in_ready, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_err", err_a, 0);
      check("rst_cond", bus_a.out_cond, 0);
      reset = 1'b0;
      check("ready_low_after_rst", bus_a.in_ready, 0);
      step();
      check("ready_rise", bus_a.in_ready, 1);

      // Streaming 0..7, latency 1, one per cycle
      bus_a.out_ready = 1'b1;
      bus_a.in_valid  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus_a.in_t = k[2:0];
         step();
         check("stream_valid", bus_a.out_valid, 1);
         check("stream_cond", bus_a.out_cond, exp_seq[k]);
      end
      bus_a.in_valid = 1'b0;
      step();
      check("stream_empty", bus_a.out_valid, 0);

      // Backpressure: 3 then 5 with out_ready low
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = 1'b1;
      bus_a.in_t      = 3'd3;
      step();
      check("bp_ready1", bus_a.in_ready, 1);
      check("bp_cond1", bus_a.out_cond, 4'h8);
      bus_a.in_t = 3'd5;
      step();
      check("bp_full_ready", bus_a.in_ready, 0);
      check("bp_cond2", bus_a.out_cond, 4'h8);
      bus_a.in_valid = 1'b0;
      step();
      check("bp_hold_valid", bus_a.out_valid, 1);
      check("bp_hold_cond", bus_a.out_cond, 4'h8);
      bus_a.out_ready = 1'b1;
      step();
      check("bp_second", bus_a.out_cond, 4'h4);
      step();
      check("bp_drained", bus_a.out_valid, 0);

      // Sweep with ideal decoder, then with chk_t forced to 0
      loop_a = 1'b1;
      run_sweep_a(0);
      loop_a = 1'b0;
      run_sweep_a(7);
      step();
      step();
      check("err_hold_idle", err_a, 7);

      // CHECK_LAT=4 sweep, forced chk_t, random stalls
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      check("sweep_b_busy", busy_b, 1);
      seen = 0;
      got  = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
         bus_b.out_ready = 1'($urandom_range(0, 1));
         if (bus_b.out_valid && bus_b.out_ready) begin
            check("sweep_b_code", bus_b.out_cond, seen * 2);
            seen++;
         end
         step();
         if (done_b) got = 1'b1;
      end
      check("sweep_b_done", got, 1);
      check("sweep_b_ncodes", seen, 8);
      check("sweep_b_err", err_b, 7);

      // Reset mid-sweep after the 4th code
      loop_a = 1'b1;
      bus_a.out_ready = 1'b1;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      seen = 0;
      for (int c = 0; c < 30 && seen < 4; c++) begin
         if (bus_a.out_valid && bus_a.out_ready) seen++;
         step();
      end
      check("abort_seen4", seen, 4);
      check("abort_busy_before", busy_a, 1);
      base = done_a_cnt;
      reset = 1'b1;
      step();
      check("abort_valid", bus_a.out_valid, 0);
      check("abort_busy", busy_a, 0);
      check("abort_done", done_a, 0);
      check("abort_err", err_a, 0);
      reset = 1'b0;
      step();
      step();
      step();
      check("abort_no_done_pulse", done_a_cnt, base);

      // sweep_start ignored while FIFO holds an entry
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = 1'b1;
      bus_a.in_t      = 3'd2;
      step();
      bus_a.in_valid = 1'b0;
      check("ign_valid", bus_a.out_valid, 1);
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      check("ign_busy", busy_a, 0);
      check("ign_ready", bus_a.in_ready, 1);
      step();
      check("ign_busy2", busy_a, 0);
      check("ign_cond", bus_a.out_cond, 4'hA);
      bus_a.out_ready = 1'b1;
      step();
      check("ign_drained", bus_a.out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/case_code_encoder.md
CASE_CODE_ENCODER -- requirements
Module: case_code_encoder

Interface
REQ-001 Parameter CHECK_LAT, default 1, cycles from an output handshake to the sampling of chk_t; legal range 1..4.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream 3-bit value in_t is valid.
REQ-005 in_ready  output  1  block accepts in_t this cycle.
REQ-006 in_t  input  3  value to encode.
REQ-007 out_valid  output  1  out_cond is valid.
REQ-008 out_ready  input  1  downstream decoder accepts out_cond.
REQ-009 out_cond  output  4  encoded condition code.
REQ-010 sweep_start  input  1  request a self-check sweep of all 8 codes.
REQ-011 sweep_busy  output  1  sweep in progress.
REQ-012 sweep_done  output  1  one-cycle pulse when a sweep completes.
REQ-013 chk_t  input  3  value returned by the downstream decoder.
REQ-014 err_count  output  4  sweep mismatch count, saturating.

Function
REQ-015 Encoding SHALL be out_cond = {~t, 1'b0}, i.e. cond = (7 - t) << 1; bit 0 of out_cond SHALL always be 0.
REQ-016 Input handshake: a value SHALL be pushed when in_valid && in_ready; output handshake SHALL complete when out_valid && out_ready.
REQ-017 A 2-entry FIFO SHALL sit between encoder and output; out_cond SHALL be the encoded head entry; order SHALL be preserved.
REQ-018 in_ready SHALL be 1 iff FIFO not full and FSM in IDLE; no combinational path from out_ready to in_ready.
REQ-019 out_valid SHALL be 1 iff FIFO not empty; out_cond SHALL hold stable while out_valid && !out_ready.
REQ-020 Minimum latency: value pushed in cycle N SHALL appear with out_valid in cycle N+1 when FIFO was empty.
REQ-021 Simultaneous push and pop with 1 entry held SHALL leave occupancy at 1; throughput SHALL be one value per cycle sustained.
REQ-022 FSM states: IDLE, SEND, DRAIN, DONE.
REQ-023 IDLE -> SEND on sweep_start only when the FIFO is empty; sweep_start in any other state, or with the FIFO non-empty, SHALL be ignored (not queued).
REQ-024 On entering SEND, err_count SHALL clear to 0 and the sweep index i SHALL be 0.
REQ-025 In SEND the block SHALL push t = 7 - i internally whenever the FIFO is not full, incrementing i; codes emitted SHALL be 0x0,0x2,...,0xE in order.
REQ-026 SEND -> DRAIN after the push with i = 7; DRAIN -> DONE once all 8 checks have been sampled; DONE -> IDLE after exactly one cycle.
REQ-027 sweep_busy SHALL be 1 in SEND and DRAIN; sweep_done SHALL be 1 only in DONE.
REQ-028 Check: for each sweep output handshake in cycle N, chk_t SHALL be sampled in cycle N+CHECK_LAT and compared to the t of that entry; mismatch increments err_count.
REQ-029 Check pipeline SHALL track up to CHECK_LAT outstanding entries; back-to-back handshakes SHALL each be checked.
REQ-030 err_count SHALL saturate at 15 and hold its value after DONE until the next accepted sweep_start or reset.
REQ-031 Outside a sweep, chk_t SHALL be ignored.

Reset
REQ-032 While reset is high at a clk edge: FIFO empty, out_valid=0, in_ready=0, FSM=IDLE, sweep_busy=0, sweep_done=0, err_count=0, check pipeline cleared, out_cond=0.
REQ-033 in_ready SHALL rise the cycle after reset deasserts.
REQ-034 Reset mid-sweep SHALL abort: pending FIFO entries and checks discarded, no sweep_done pulse.

Verification
REQ-035 in_t=0..7 pushed, out_ready=1 -> out_cond = 0xE,0xC,0xA,0x8,0x6,0x4,0x2,0x0, one per cycle, latency 1.
REQ-036 Push 3, 5 with out_ready=0 -> in_ready=0 after 2 pushes, out_cond=0x8 held; raise out_ready -> 0x8 then 0x4.
REQ-037 sweep_start with chk_t looped from an ideal decoder (CHECK_LAT=1) -> codes 0x0..0xE, sweep_done after last check, err_count=0.
REQ-038 Sweep with chk_t forced to 3'b000 -> 7 mismatches, err_count=7; forced with CHECK_LAT=4 and random out_ready stalls -> same result.
REQ-039 Reset asserted after 4th sweep code -> out_valid=0, sweep_busy=0, no sweep_done; sweep_start while FIFO holds an entry -> ignored, sweep_busy stays 0.
